// File: rtl/fsm_oe16s_sequencer.sv
// Table-driven sequencer for the 16-state one-hot universal FSM: dwells, evaluates one condition, fires one transition.
// Optional table readback port is enabled with `define FSM_SEQ_READBACK_EN.
//
// state | meaning
// IDLE  | t_x holds every FSM state; config writes accepted
// SYNC  | encode st, load dwell counter, maybe evaluate at once
// DWELL | count down dwell; evaluate condition when counter = 1
// FIRE  | t_x drives the latched target on the current state's nibble
module fsm_oe16s_sequencer #(
  parameter int DWELL_W = 8,
  parameter int NCOND   = 4,
  localparam int CSEL_W = (NCOND > 1) ? $clog2(NCOND) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [NCOND-1:0]   cond,
  input  logic [15:0]        st,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_addr,
  input  logic [3:0]         cfg_nxt_t,
  input  logic [3:0]         cfg_nxt_f,
  input  logic [CSEL_W-1:0]  cfg_csel,
  input  logic [DWELL_W-1:0] cfg_dwell,
`ifdef FSM_SEQ_READBACK_EN
  input  logic [3:0]         cfg_raddr,
  output logic [DWELL_W+8+CSEL_W-1:0] cfg_rdata,
`endif
  output logic [63:0]        t_x,
  output logic               busy,
  output logic               cfg_err,
  output logic               onehot_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_DWELL = 2'd2;
  localparam logic [1:0] ST_FIRE  = 2'd3;

  localparam logic [63:0] HOLD = 64'hFEDC_BA98_7654_3210;

  logic [1:0]         state;
  logic [3:0]         cur;
  logic [DWELL_W-1:0] cnt;

  logic [3:0]         tab_nxt_t [16];
  logic [3:0]         tab_nxt_f [16];
  logic [CSEL_W-1:0]  tab_csel  [16];
  logic [DWELL_W-1:0] tab_dwell [16];

  logic [3:0] st_idx;
  logic       st_onehot;
  logic [3:0] eval_idx;
  logic [3:0] eval_tgt;

  function automatic logic [63:0] fire_pat(input logic [3:0] idx, input logic [3:0] tgt);
    logic [63:0] p;
    p = HOLD;
    p[{idx, 2'b00} +: 4] = tgt;
    return p;
  endfunction

  always_comb begin
    st_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (st[i]) st_idx = st_idx | 4'(i);
    end
  end

  assign st_onehot = (st != 16'd0) && ((st & (st - 16'd1)) == 16'd0);

  // In SYNC the table is indexed by the freshly encoded state, later by the latched one.
  assign eval_idx = (state == ST_SYNC) ? st_idx : cur;
  assign eval_tgt = cond[tab_csel[eval_idx]] ? tab_nxt_t[eval_idx] : tab_nxt_f[eval_idx];

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        tab_nxt_t[i] <= 4'(i);
        tab_nxt_f[i] <= 4'(i);
        tab_csel[i]  <= '0;
        tab_dwell[i] <= '0;
      end
    end else if (cfg_we && (state == ST_IDLE)) begin
      tab_nxt_t[cfg_addr] <= cfg_nxt_t;
      tab_nxt_f[cfg_addr] <= cfg_nxt_f;
      tab_csel[cfg_addr]  <= cfg_csel;
      tab_dwell[cfg_addr] <= cfg_dwell;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur        <= 4'd0;
      cnt        <= '0;
      t_x        <= HOLD;
      cfg_err    <= 1'b0;
      onehot_err <= 1'b0;
    end else begin
      // t_x only departs from HOLD for the single cycle spent in FIRE.
      t_x <= HOLD;
      if (cfg_we && (state != ST_IDLE)) cfg_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state      <= ST_SYNC;
            cfg_err    <= 1'b0;
            onehot_err <= 1'b0;
          end
        end
        ST_SYNC: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (!st_onehot) begin
            onehot_err <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            cur <= st_idx;
            cnt <= tab_dwell[st_idx];
            if (tab_dwell[st_idx] == '0) begin
              t_x   <= fire_pat(st_idx, eval_tgt);
              state <= ST_FIRE;
            end else begin
              state <= ST_DWELL;
            end
          end
        end
        ST_DWELL: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (cnt == DWELL_W'(1)) begin
            t_x   <= fire_pat(cur, eval_tgt);
            state <= ST_FIRE;
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end
        ST_FIRE: begin
          state <= stop ? ST_IDLE : ST_SYNC;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FSM_SEQ_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_rdata <= '0;
    end else begin
      cfg_rdata <= {tab_dwell[cfg_raddr], tab_csel[cfg_raddr],
                    tab_nxt_f[cfg_raddr], tab_nxt_t[cfg_raddr]};
    end
  end
`else
  // No readback path: the table is write-only.
`endif

endmodule

// File: tb/tb_fsm_oe16s_sequencer.sv
// Directed, table-driven bench for fsm_oe16s_sequencer with a behavioural 16-state one-hot FSM alongside.
module tb_fsm_oe16s_sequencer;

  localparam logic [63:0] H   = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] F03 = 64'hFEDC_BA98_7654_3213;
  localparam logic [63:0] F30 = 64'hFEDC_BA98_7654_0210;
  localparam logic [63:0] F59 = 64'hFEDC_BA98_7694_3210;
  localparam logic [63:0] F5C = 64'hFEDC_BA98_76C4_3210;

  logic        clk, rst_n, start, stop, cfg_we;
  logic [3:0]  cond, cfg_addr, cfg_nxt_t, cfg_nxt_f;
  logic [1:0]  cfg_csel;
  logic [7:0]  cfg_dwell;
  logic [15:0] st, st_force;
  logic        st_force_en;
  logic [63:0] t_x;
  logic        busy, cfg_err, onehot_err;
`ifdef FSM_SEQ_READBACK_EN
  logic [3:0]  cfg_raddr;
  logic [17:0] cfg_rdata;
`endif

  logic [3:0] fsm_idx, fsm_preset;
  logic       fsm_load;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic        start;
    logic        stop;
    logic [3:0]  cond;
    logic        exp_busy;
    logic [63:0] exp_tx;
    logic [3:0]  exp_fsm;
  } vec_t;

  vec_t vecs[14];

  fsm_oe16s_sequencer #(.DWELL_W(8), .NCOND(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cond(cond), .st(st),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_nxt_t(cfg_nxt_t), .cfg_nxt_f(cfg_nxt_f),
    .cfg_csel(cfg_csel), .cfg_dwell(cfg_dwell),
`ifdef FSM_SEQ_READBACK_EN
    .cfg_raddr(cfg_raddr), .cfg_rdata(cfg_rdata),
`endif
    .t_x(t_x), .busy(busy), .cfg_err(cfg_err), .onehot_err(onehot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Universal FSM model: from state y it moves to t<y>x every clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_idx <= 4'd0;
    else if (fsm_load) fsm_idx <= fsm_preset;
    else fsm_idx <= t_x[{fsm_idx, 2'b00} +: 4];
  end

  assign st = st_force_en ? st_force : (16'h0001 << fsm_idx);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    start = v.start;
    stop  = v.stop;
    cond  = v.cond;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    chk({v.name, ".busy"}, 64'(busy), 64'(v.exp_busy));
    chk({v.name, ".t_x"}, t_x, v.exp_tx);
    chk({v.name, ".fsm"}, 64'(fsm_idx), 64'(v.exp_fsm));
  endtask

  function automatic vec_t mk(input string name, input logic sa, input logic so, input logic [3:0] c,
                              input logic eb, input logic [63:0] et, input logic [3:0] ef);
    vec_t v;
    v.name = name; v.start = sa; v.stop = so; v.cond = c;
    v.exp_busy = eb; v.exp_tx = et; v.exp_fsm = ef;
    return v;
  endfunction

  task automatic cfg_write(input logic [3:0] a, input logic [3:0] nt, input logic [3:0] nf,
                           input logic [1:0] cs, input logic [7:0] dw);
    cfg_we = 1'b1; cfg_addr = a; cfg_nxt_t = nt; cfg_nxt_f = nf; cfg_csel = cs; cfg_dwell = dw;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic set_fsm(input logic [3:0] s);
    fsm_load = 1'b1; fsm_preset = s;
    @(posedge clk); #1;
    fsm_load = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk("t1_start", 1, 0, 4'h0, 1, H, 0);
    vecs[1]  = mk("t1_fire0", 0, 0, 4'h0, 1, H, 0);
    vecs[2]  = mk("t1_sync",  0, 0, 4'h0, 1, H, 0);
    vecs[3]  = mk("t1_fire1", 0, 0, 4'h0, 1, H, 0);
    vecs[4]  = mk("t1_stop",  0, 1, 4'h0, 0, H, 0);
    vecs[5]  = mk("t2_start", 1, 0, 4'h1, 1, H, 0);
    vecs[6]  = mk("t2_dw2",   0, 0, 4'h1, 1, H, 0);
    vecs[7]  = mk("t2_dw1",   0, 0, 4'h1, 1, H, 0);
    vecs[8]  = mk("t2_fire0", 0, 0, 4'h1, 1, F03, 0);
    vecs[9]  = mk("t2_sync3", 0, 0, 4'h1, 1, H, 3);
    vecs[10] = mk("t2_fire3", 0, 0, 4'h1, 1, F30, 3);
    vecs[11] = mk("t2_sync0", 0, 0, 4'h1, 1, H, 0);
    vecs[12] = mk("t2_dwell", 0, 0, 4'h1, 1, H, 0);
    vecs[13] = mk("t2_stop",  0, 1, 4'h1, 0, H, 0);

    rst_n = 1'b0; start = 0; stop = 0; cond = 0; cfg_we = 0;
    cfg_addr = 0; cfg_nxt_t = 0; cfg_nxt_f = 0; cfg_csel = 0; cfg_dwell = 0;
    st_force = 16'h0; st_force_en = 0; fsm_load = 0; fsm_preset = 0;
`ifdef FSM_SEQ_READBACK_EN
    cfg_raddr = 4'd0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.t_x", t_x, H);
    chk("rst.cfg_err", 64'(cfg_err), 64'd0);
    chk("rst.onehot_err", 64'(onehot_err), 64'd0);

    // Default table: self-loops with zero dwell.
    for (int i = 0; i < 5; i++) apply(vecs[i]);

    // S0 -> S3 after dwell 2, S3 -> S0 immediately.
    cfg_write(4'd0, 4'd3, 4'd0, 2'd0, 8'd2);
    cfg_write(4'd3, 4'd0, 4'd3, 2'd0, 8'd0);
    for (int i = 5; i < 14; i++) apply(vecs[i]);

    // Conditional branch from S5 on cond[2], other cycles and bits toggled as noise.
    cfg_write(4'd5, 4'd9, 4'd12, 2'd2, 8'd1);
    set_fsm(4'd5);
    apply(mk("t3a_start", 1, 0, 4'b0000, 1, H, 5));
    apply(mk("t3a_sync",  0, 0, 4'b1011, 1, H, 5));
    apply(mk("t3a_fire",  0, 0, 4'b0100, 1, F59, 5));
    apply(mk("t3a_s9",    0, 0, 4'b0000, 1, H, 9));
    apply(mk("t3a_stop",  0, 1, 4'b0000, 0, H, 9));
    set_fsm(4'd5);
    apply(mk("t3b_start", 1, 0, 4'b0100, 1, H, 5));
    apply(mk("t3b_sync",  0, 0, 4'b0100, 1, H, 5));
    apply(mk("t3b_fire",  0, 0, 4'b1011, 1, F5C, 5));
    apply(mk("t3b_s12",   0, 0, 4'b0100, 1, H, 12));
    apply(mk("t3b_stop",  0, 1, 4'b0100, 0, H, 12));

    // Write while busy is dropped and flagged; cleared on next start.
    set_fsm(4'd7);
    apply(mk("t4_start", 1, 0, 4'h0, 1, H, 7));
    cfg_we = 1'b1; cfg_addr = 4'd7; cfg_nxt_t = 4'd1; cfg_nxt_f = 4'd1; cfg_csel = 2'd0; cfg_dwell = 8'd0;
    apply(mk("t4_busywr", 0, 0, 4'h0, 1, H, 7));
    cfg_we = 1'b0;
    chk("t4.cfg_err_set", 64'(cfg_err), 64'd1);
    apply(mk("t4_sync", 0, 0, 4'h0, 1, H, 7));
    apply(mk("t4_stop", 0, 1, 4'h0, 0, H, 7));
    chk("t4.cfg_err_sticky", 64'(cfg_err), 64'd1);
    apply(mk("t4_restart", 1, 0, 4'h0, 1, H, 7));
    chk("t4.cfg_err_clr", 64'(cfg_err), 64'd0);
    apply(mk("t4_fire7", 0, 0, 4'h0, 1, H, 7));
    apply(mk("t4_still7", 0, 0, 4'h0, 1, H, 7));
    apply(mk("t4_stop2", 0, 1, 4'h0, 0, H, 7));

    // Stop during FIRE still completes the transition; start+stop in IDLE is ignored.
    set_fsm(4'd0);
    apply(mk("t5_start", 1, 0, 4'h1, 1, H, 0));
    apply(mk("t5_dw2",   0, 0, 4'h1, 1, H, 0));
    apply(mk("t5_dw1",   0, 0, 4'h1, 1, H, 0));
    apply(mk("t5_fire",  0, 0, 4'h1, 1, F03, 0));
    apply(mk("t5_stopf", 0, 1, 4'h1, 0, H, 3));
    apply(mk("t5_both",  1, 1, 4'h1, 0, H, 3));
    apply(mk("t5_idle",  0, 0, 4'h1, 0, H, 3));

    // Non-one-hot st aborts in SYNC.
    st_force = 16'h0011; st_force_en = 1'b1;
    apply(mk("t6_start", 1, 0, 4'h1, 1, H, 3));
    apply(mk("t6_abort", 0, 0, 4'h1, 0, H, 3));
    chk("t6.onehot_err", 64'(onehot_err), 64'd1);
    st_force_en = 1'b0;

    // Async reset mid-DWELL restores outputs and table.
    set_fsm(4'd0);
    apply(mk("t6_start2", 1, 0, 4'h1, 1, H, 0));
    chk("t6.onehot_clr", 64'(onehot_err), 64'd0);
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_nxt_t = 4'd4; cfg_nxt_f = 4'd4; cfg_csel = 2'd0; cfg_dwell = 8'd0;
    apply(mk("t6_dw", 0, 0, 4'h1, 1, H, 0));
    cfg_we = 1'b0;
    chk("t6.cfg_err_set", 64'(cfg_err), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("t6.rst_busy", 64'(busy), 64'd0);
    chk("t6.rst_t_x", t_x, H);
    chk("t6.rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("t6.rst_onehot_err", 64'(onehot_err), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    apply(mk("t6_r0_start", 1, 0, 4'h1, 1, H, 0));
    apply(mk("t6_r0_fire",  0, 0, 4'h1, 1, H, 0));
    apply(mk("t6_r0_sync",  0, 0, 4'h1, 1, H, 0));
    apply(mk("t6_r0_fire2", 0, 0, 4'h1, 1, H, 0));
    apply(mk("t6_r0_sync2", 0, 0, 4'h1, 1, H, 0));
    apply(mk("t6_r0_stop",  0, 1, 4'h1, 0, H, 0));
    set_fsm(4'd5);
    apply(mk("t6_r5_start", 1, 0, 4'b0100, 1, H, 5));
    apply(mk("t6_r5_fire",  0, 0, 4'b0100, 1, H, 5));
    apply(mk("t6_r5_sync",  0, 0, 4'b0100, 1, H, 5));
    apply(mk("t6_r5_stop",  0, 1, 4'b0100, 0, H, 5));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
